fsm_event_sequencer: RTL
========================

// Module: fsm_event_sequencer
// PURPOSE
//  Schedules event pulses into the small control FSM (inputs a/b/f/g, outputs c/d/e/h).
//  N requesters compete for the FSM event inputs; round-robin arbitration grants one at a time.
//  Each grant drives a single-cycle pulse on one FSM event input, then waits for an FSM acknowledge or a timeout.
//  A guard gap follows every command. Sits between software/test stimulus and the FSM instance.
// PARAMETERS
//  N_REQ       4   number of requesters / FSM event inputs (ev_out[i] maps to a,b,f,g for i=0..3)
//  GAP_CYCLES  2   idle cycles enforced after each completed or timed-out command (0 allowed)
//  TIMEOUT     16  max WAIT_ACK cycles before abort (>=2)
//  CNT_W       5   width of gap/timeout counter; must hold max(GAP_CYCLES,TIMEOUT)
//  ERR_W       8   width of saturating timeout error counter
// PORTS
//  clk      in   1       clock, rising edge
//  rst      in   1       asynchronous, active-high reset
//  req      in   N_REQ   level requests; hold until granted
//  grant    out  N_REQ   one-hot, 1-cycle pulse to winning requester
//  ev_out   out  N_REQ   one-hot, 1-cycle event pulse to FSM (same cycle as grant)
//  fsm_ack  in   1       FSM completion indication (e.g. OR of c/d/e/h as wired at top)
//  done     out  1       1-cycle pulse: command acknowledged
//  timeout  out  1       1-cycle pulse: command aborted by timeout
//  busy     out  1       high in every state except IDLE
//  err_cnt  out  ERR_W   saturating count of timeouts
// BEHAVIOUR
//  Reset (async assert, sync to clk on release): state=IDLE, rr pointer=0, counter=0, all outputs 0.
//  Reset mid-command abandons it: no done/timeout pulse, err_cnt cleared.
//  States: IDLE -> ISSUE -> WAIT_ACK -> GAP -> IDLE (GAP skipped when GAP_CYCLES=0).
//  IDLE: if |req, latch winner index (rr order starting at pointer), go ISSUE next cycle.
//   Latency: req high in cycle t (in IDLE) -> grant/ev_out high in cycle t+1.
//  ISSUE (exactly 1 cycle): grant[w]=ev_out[w]=1; pointer <= (w+1) mod N_REQ; counter<=0; go WAIT_ACK.
//   Winner is latched: a req drop after IDLE sampling still gets its grant. fsm_ack ignored in ISSUE.
//  WAIT_ACK: counter increments each cycle.
//   fsm_ack=1 -> done pulse (registered, cycle after ack is seen), go GAP.
//   else counter==TIMEOUT-1 -> timeout pulse, err_cnt+1 (saturates at all-ones), go GAP.
//   ack and timeout in same cycle: ack wins, no timeout, err_cnt unchanged.
//  GAP: hold GAP_CYCLES cycles (counter reloaded 0, exits when counter==GAP_CYCLES-1); req ignored.
//  busy: combinational from state != IDLE. grant/ev_out/done/timeout registered, never overlap.
//  Back-to-back: a requester holding req continuously is re-granted only after all others with
//   pending req have been served once (fairness bound: N_REQ commands).
//  Arbiter: rotate-priority search from pointer; pointer updates only on a grant.
// STRUCTURE
//  fsm_seq_defs.vh: state encodings (IDLE=2'd0, ISSUE=2'd1, WAIT_ACK=2'd2, GAP=2'd3), default params.
//  Sub-module rr_arbiter (req, pointer -> one-hot winner + index), purely combinational, N_REQ param.
//  Top: state register, counter, pointer, err_cnt, output registers.
// TESTING
//  1 Reset: rst=1 with req=4'b1111 -> all outputs 0, busy=0; release, req=0 -> stays IDLE.
//  2 Single: req=4'b0010 at t0 -> grant=ev_out=4'b0010 at t0+1; fsm_ack at t0+3 -> done at t0+4; busy low at t0+6 (GAP=2).
//  3 Round-robin: req=4'b1111 held, ack 1 cycle after each issue -> grants 0001,0010,0100,1000,0001 in order.
//  4 Timeout: req=4'b0001, no ack -> timeout pulse after 16 WAIT_ACK cycles, err_cnt=1; repeat 256x -> err_cnt=255 (saturated).
//  5 Ack on last timeout cycle (counter=15) -> done=1, timeout=0, err_cnt unchanged.
//  6 Reset mid-WAIT_ACK -> outputs 0 immediately (async), no done/timeout, next grant starts at requester 0.

Source files
------------

// File: rtl/fsm_event_sequencer_pkg.sv
// fsm_event_sequencer_pkg: shared state encoding, default parameters and index-width helper
package fsm_event_sequencer_pkg;
  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    ISSUE    = 2'd1,
    WAIT_ACK = 2'd2,
    GAP      = 2'd3
  } state_t;
  localparam int DEF_N_REQ      = 4;
  localparam int DEF_GAP_CYCLES = 2;
  localparam int DEF_TIMEOUT    = 16;
  localparam int DEF_CNT_W      = 5;
  localparam int DEF_ERR_W      = 8;
  function automatic int idx_w(input int n);
    return n > 1 ? $clog2(n) : 1;
  endfunction
endpackage

// File: rtl/fsm_event_sequencer_rr_arbiter.sv
// fsm_event_sequencer_rr_arbiter: combinational rotate-priority search starting at ptr
//   req    in  N_REQ  pending requests
//   ptr    in  IW     highest-priority requester index
//   winner out N_REQ  one-hot winner (zero when no request)
//   idx    out IW     winner index
module fsm_event_sequencer_rr_arbiter
  import fsm_event_sequencer_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int IW    = idx_w(N_REQ)
) (
  input  logic [N_REQ-1:0] req,
  input  logic [IW-1:0]    ptr,
  output logic [N_REQ-1:0] winner,
  output logic [IW-1:0]    idx
);
  // Descending scan so the smallest offset from ptr is the last (winning) assignment.
  always_comb begin
    idx = '0;
    for (int i = N_REQ - 1; i >= 0; i--)
      if (req[(int'(ptr) + i) % N_REQ]) idx = IW'((int'(ptr) + i) % N_REQ);
  end
  assign winner = |req ? N_REQ'(1) << idx : '0;
endmodule

// File: rtl/fsm_event_sequencer.sv
// fsm_event_sequencer: round-robin scheduler of single-cycle event pulses into the control FSM
//   clk     in  1      clock, rising edge
//   rst     in  1      asynchronous active-high reset
//   req     in  N_REQ  level requests, held until granted
//   grant   out N_REQ  one-hot 1-cycle grant to the winner
//   ev_out  out N_REQ  one-hot 1-cycle FSM event pulse, coincident with grant
//   fsm_ack in  1      FSM completion indication
//   done    out 1      1-cycle pulse: command acknowledged
//   timeout out 1      1-cycle pulse: command aborted
//   busy    out 1      high whenever not IDLE
//   err_cnt out ERR_W  saturating timeout count
module fsm_event_sequencer
  import fsm_event_sequencer_pkg::*;
#(
  parameter int N_REQ      = DEF_N_REQ,
  parameter int GAP_CYCLES = DEF_GAP_CYCLES,
  parameter int TIMEOUT    = DEF_TIMEOUT,
  parameter int CNT_W      = DEF_CNT_W,
  parameter int ERR_W      = DEF_ERR_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] grant,
  output logic [N_REQ-1:0] ev_out,
  input  logic             fsm_ack,
  output logic             done,
  output logic             timeout,
  output logic             busy,
  output logic [ERR_W-1:0] err_cnt
);
  localparam int IW = idx_w(N_REQ);
  localparam logic [CNT_W-1:0] TO_LAST  = CNT_W'(TIMEOUT - 1);
  localparam logic [CNT_W-1:0] GAP_LAST = CNT_W'(GAP_CYCLES > 0 ? GAP_CYCLES - 1 : 0);
  // With no guard gap a finished command returns straight to IDLE.
  localparam state_t AFTER_CMD = GAP_CYCLES > 0 ? GAP : IDLE;
  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [IW-1:0]    ptr;
  logic [IW-1:0]    win;
  logic [N_REQ-1:0] arb_hot;
  logic [IW-1:0]    arb_idx;
  logic             expire;
  fsm_event_sequencer_rr_arbiter #(.N_REQ(N_REQ), .IW(IW)) u_arb (
    .req   (req),
    .ptr   (ptr),
    .winner(arb_hot),
    .idx   (arb_idx)
  );
  // Ack on the final timeout cycle takes precedence over the abort.
  assign expire = !fsm_ack && cnt == TO_LAST;
  assign busy   = state != IDLE;
  assign ev_out = grant;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      cnt     <= '0;
      ptr     <= '0;
      win     <= '0;
      grant   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      err_cnt <= '0;
    end else begin
      grant   <= '0;
      done    <= 1'b0;
      timeout <= 1'b0;
      case (state)
        IDLE: if (|req) begin
          win   <= arb_idx;
          grant <= arb_hot;
          state <= ISSUE;
        end
        ISSUE: begin
          ptr   <= IW'((int'(win) + 1) % N_REQ);
          cnt   <= '0;
          state <= WAIT_ACK;
        end
        WAIT_ACK: begin
          done    <= fsm_ack;
          timeout <= expire;
          cnt     <= fsm_ack || expire ? '0 : cnt + 1'b1;
          state   <= fsm_ack || expire ? AFTER_CMD : WAIT_ACK;
          if (expire && !(&err_cnt)) err_cnt <= err_cnt + 1'b1;
        end
        GAP: begin
          cnt   <= cnt == GAP_LAST ? '0 : cnt + 1'b1;
          state <= cnt == GAP_LAST ? IDLE : GAP;
        end
      endcase
    end
  end
endmodule
